// File: rtl/jiafa_bcd_counter_if.sv
// Push-button/display bundle of the two-digit BCD up-counter.
// The board side (master) drives the raw key and clear; the counter (slave) drives count and display.
interface jiafa_bcd_counter_if;
    logic       anjian;
    logic       clr;
    logic [7:0] count_bcd;
    logic       carry;
    logic [6:0] seg_n;
    logic [1:0] dig_sel_n;

    modport master (
        output anjian,
        output clr,
        input  count_bcd,
        input  carry,
        input  seg_n,
        input  dig_sel_n
    );

    modport slave (
        input  anjian,
        input  clr,
        output count_bcd,
        output carry,
        output seg_n,
        output dig_sel_n
    );
endinterface

// File: rtl/jiafa_bcd_counter.sv
// Two-digit BCD up-counter advanced by a debounced push-button, with synchronous clear,
// wrap carry pulse and a multiplexed active-low 7-segment drive.
module jiafa_bcd_counter #(
    parameter int DEB_CYCLES = 4,
    parameter int SCAN_DIV   = 8,
    parameter int MODULO     = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    jiafa_bcd_counter_if.slave    bus
);

    localparam logic [7:0]  DEB_MAX   = 8'(DEB_CYCLES);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  MAX_TENS  = 4'((MODULO - 1) / 10);
    localparam logic [3:0]  MAX_UNITS = 4'((MODULO - 1) % 10);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        P_WAIT  = 2'd1,
        PRESSED = 2'd2,
        R_WAIT  = 2'd3
    } deb_state_t;

    logic        r_sync1;
    logic        r_sync2;
    logic        w_key_s;

    deb_state_t  r_state;
    deb_state_t  w_state_nxt;
    logic [7:0]  r_deb_cnt;
    logic [7:0]  w_deb_cnt_nxt;
    logic        r_inc;
    logic        w_inc_nxt;

    logic [3:0]  r_units;
    logic [3:0]  r_tens;
    logic        r_carry;
    logic        w_at_max;

    logic [15:0] r_scan_cnt;
    logic [1:0]  r_dig_sel_n;
    logic [3:0]  w_digit;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous key
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.anjian;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_s = r_sync2;

    // ------------------------------------------------------------------
    // Debounce FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_deb_cnt <= 8'd0;
            r_inc     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_cnt_nxt;
            r_inc     <= w_inc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM: next state and the one-shot increment request
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        w_state_nxt   = r_state;
        w_deb_cnt_nxt = r_deb_cnt;
        w_inc_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_key_s) begin
                    w_state_nxt   = P_WAIT;
                    w_deb_cnt_nxt = 8'd1;
                end
            end
            P_WAIT: begin
                if (!w_key_s) begin
                    w_state_nxt = IDLE;
                end else if (r_deb_cnt == DEB_MAX) begin
                    w_state_nxt = PRESSED;
                    w_inc_nxt   = 1'b1;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 8'd1;
                end
            end
            PRESSED: begin
                // Holding the key parks here; only a qualified release re-arms the FSM.
                if (!w_key_s) begin
                    w_state_nxt   = R_WAIT;
                    w_deb_cnt_nxt = 8'd1;
                end
            end
            R_WAIT: begin
                if (w_key_s) begin
                    w_state_nxt = PRESSED;
                end else if (r_deb_cnt == DEB_MAX) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // BCD count with clear priority over increment
    // ------------------------------------------------------------------
    assign w_at_max = (r_tens == MAX_TENS) && (r_units == MAX_UNITS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_units <= 4'd0;
            r_tens  <= 4'd0;
            r_carry <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (bus.clr) begin
                r_units <= 4'd0;
                r_tens  <= 4'd0;
            end else if (r_inc) begin
                if (w_at_max) begin
                    r_units <= 4'd0;
                    r_tens  <= 4'd0;
                    r_carry <= 1'b1;
                end else if (r_units == 4'd9) begin
                    r_units <= 4'd0;
                    r_tens  <= r_tens + 4'd1;
                end else begin
                    r_units <= r_units + 4'd1;
                end
            end
        end
    end

    assign bus.count_bcd = {r_tens, r_units};
    assign bus.carry     = r_carry;

    // ------------------------------------------------------------------
    // Display scan: one digit enabled at a time, swapped every SCAN_DIV clocks
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt  <= 16'd0;
            r_dig_sel_n <= 2'b10;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt  <= 16'd0;
            r_dig_sel_n <= ~r_dig_sel_n;
        end else begin
            r_scan_cnt  <= r_scan_cnt + 16'd1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign w_digit       = r_dig_sel_n[0] ? r_tens : r_units;
    assign bus.seg_n     = seg7(w_digit);
    assign bus.dig_sel_n = r_dig_sel_n;

endmodule

// File: tb/tb_jiafa_bcd_counter.sv
// Directed bench for jiafa_bcd_counter: reset, debounce latency, bounce rejection,
// BCD carry/wrap for MODULO=100 and MODULO=60, clear-vs-increment priority and display scan.
module tb_jiafa_bcd_counter;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG5 = 7'b0010010;
    localparam logic [6:0] SEG8 = 7'b0000000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic anjian = 1'b0;
    logic clr    = 1'b0;

    int errors = 0;
    int checks = 0;
    int m100   = 0;
    int m60    = 0;

    jiafa_bcd_counter_if bus100 ();
    jiafa_bcd_counter_if bus60 ();

    assign bus100.anjian = anjian;
    assign bus100.clr    = clr;
    assign bus60.anjian  = anjian;
    assign bus60.clr     = clr;

    jiafa_bcd_counter #(.DEB_CYCLES(4), .SCAN_DIV(8), .MODULO(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus100.slave)
    );

    jiafa_bcd_counter #(.DEB_CYCLES(4), .SCAN_DIV(8), .MODULO(60)) dut60 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus60.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press with exact timing: count steps 7 edges after the key is seen at a clock edge.
    task automatic press();
        anjian = 1'b1;
        tick(7);
        chk("pre_inc_100", bus100.count_bcd, to_bcd(m100));
        chk("pre_inc_60",  bus60.count_bcd,  to_bcd(m60));
        m100 = (m100 + 1) % 100;
        m60  = (m60 + 1) % 60;
        tick(1);
        chk("count_100", bus100.count_bcd, to_bcd(m100));
        chk("count_60",  bus60.count_bcd,  to_bcd(m60));
        chk("carry_100", bus100.carry, (m100 == 0));
        chk("carry_60",  bus60.carry,  (m60 == 0));
        tick(1);
        chk("carry_drop_100", bus100.carry, 1'b0);
        chk("carry_drop_60",  bus60.carry,  1'b0);
        tick(3);
        anjian = 1'b0;
        tick(10);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m100 = 0;
        m60  = 0;
        chk("clr_100", bus100.count_bcd, 8'h00);
        chk("clr_60",  bus60.count_bcd,  8'h00);
    endtask

    initial begin
        logic       bounce_lvl [12];
        int         bounce_len [12];
        logic [1:0] prev_dig;
        logic [1:0] cur_dig;
        bit         toggled;

        bounce_lvl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bounce_len = '{1, 1, 2, 2, 3, 1, 12, 1, 2, 2, 1, 10};

        // Reset state, visible while reset is held
        tick(3);
        chk("rst_count", bus100.count_bcd, 8'h00);
        chk("rst_carry", bus100.carry, 1'b0);
        chk("rst_dig",   bus100.dig_sel_n, 2'b10);
        chk("rst_seg",   bus100.seg_n, SEG0);
        reset = 1'b1;
        tick(2);

        // Clean press: one increment, none while held
        anjian = 1'b1;
        tick(7);
        chk("lat_before", bus100.count_bcd, 8'h00);
        tick(1);
        chk("lat_edge", bus100.count_bcd, 8'h01);
        tick(20);
        chk("hold_no_retrig", bus100.count_bcd, 8'h01);
        anjian = 1'b0;
        tick(10);
        m100 = 1;
        m60  = 1;

        // Bouncy press and release: one increment
        for (int i = 0; i < 12; i++) begin
            anjian = bounce_lvl[i];
            tick(bounce_len[i]);
        end
        chk("bounce_single", bus100.count_bcd, 8'h02);
        // Isolated 3-clock glitch: ignored
        anjian = 1'b1;
        tick(3);
        anjian = 1'b0;
        tick(15);
        chk("glitch_ignored", bus100.count_bcd, 8'h02);
        m100 = 2;
        m60  = 2;

        // 100 presses from 00: crosses 09->10, 99->00 (and 59->00 for MODULO=60)
        do_clear();
        for (int i = 0; i < 100; i++) press();
        chk("wrap_100_final", bus100.count_bcd, 8'h00);
        chk("wrap_60_final",  bus60.count_bcd,  8'h40);

        // Clear coincident with an increment wins and the held key adds nothing afterwards
        do_clear();
        for (int i = 0; i < 42; i++) press();
        chk("at_42", bus100.count_bcd, 8'h42);
        anjian = 1'b1;
        tick(7);
        chk("pre_clr_42", bus100.count_bcd, 8'h42);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m100 = 0;
        m60  = 0;
        chk("clr_vs_inc_count", bus100.count_bcd, 8'h00);
        chk("clr_vs_inc_carry", bus100.carry, 1'b0);
        tick(12);
        chk("clr_no_late_inc", bus100.count_bcd, 8'h00);
        anjian = 1'b0;
        tick(10);
        chk("clr_after_release", bus100.count_bcd, 8'h00);

        // Display scan at 58
        for (int i = 0; i < 58; i++) press();
        chk("at_58", bus100.count_bcd, 8'h58);
        prev_dig = bus100.dig_sel_n;
        toggled  = 1'b0;
        for (int i = 0; i < 20 && !toggled; i++) begin
            tick(1);
            if (bus100.dig_sel_n !== prev_dig) toggled = 1'b1;
        end
        chk("scan_toggle_seen", toggled, 1'b1);
        chk("scan_one_hot", (bus100.dig_sel_n == 2'b10) || (bus100.dig_sel_n == 2'b01), 1'b1);
        cur_dig = ~prev_dig;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 8; i++) begin
                chk("scan_dig", bus100.dig_sel_n, cur_dig);
                chk("scan_seg", bus100.seg_n, (cur_dig == 2'b01) ? SEG5 : SEG8);
                tick(1);
            end
            cur_dig = ~cur_dig;
        end

        // Asynchronous reset mid-count, key held through reset
        do_clear();
        for (int i = 0; i < 37; i++) press();
        chk("at_37", bus100.count_bcd, 8'h37);
        anjian = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_count", bus100.count_bcd, 8'h00);
        chk("async_rst_carry", bus100.carry, 1'b0);
        chk("async_rst_dig",   bus100.dig_sel_n, 2'b10);
        chk("async_rst_seg",   bus100.seg_n, SEG0);
        tick(3);
        reset = 1'b1;
        tick(7);
        chk("held_requal_before", bus100.count_bcd, 8'h00);
        tick(1);
        chk("held_requal_edge", bus100.count_bcd, 8'h01);
        tick(12);
        chk("held_requal_once", bus100.count_bcd, 8'h01);
        anjian = 1'b0;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
